// File: rtl/flag_unit.sv
// rtl/flag_unit.sv - two-stage pipelined ALU result/flag generator feeding the 6-bit flag register
// Optional zero-result counter (zero_cnt/zero_cnt_clr) is built when FLAG_ZERO_CNT_EN is defined.
module flag_unit #(
    parameter int WIDTH     = 16,
    parameter bit SIGNED_GT = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             stall,
    input  logic             flush,
`ifdef FLAG_ZERO_CNT_EN
    input  logic             zero_cnt_clr,
    output logic [15:0]      zero_cnt,
`endif
    output logic [WIDTH-1:0] result_out,
    output logic             result_we,
    output logic [5:0]       flags_out,
    output logic             flags_valid
);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_CMP = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_OR  = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;
    localparam logic [2:0] OP_ADC = 3'd6;

    localparam int F_C  = 0;
    localparam int F_Z  = 1;
    localparam int F_S  = 2;
    localparam int F_GT = 3;
    localparam int F_EQ = 4;
    localparam int F_P  = 5;

    logic             s1_valid_q;
    logic [2:0]       s1_op_q;
    logic [WIDTH-1:0] s1_a_q;
    logic [WIDTH-1:0] s1_b_q;
    logic [WIDTH-1:0] result_q;
    logic [5:0]       flags_q;
    logic             flags_valid_q;
    logic             result_we_q;

    logic [WIDTH-1:0] result_d;
    logic [5:0]       flags_d;
    logic             result_we_d;

    logic [WIDTH:0]   sum_w;
    logic [WIDTH:0]   diff_w;
    logic [WIDTH-1:0] alu_r;
    logic             gt_w;
    logic             c_nxt;
    logic             gt_nxt;
    logic             eq_nxt;
    logic             upd_zsp;

    // Carry-in is read from the committed flags in stage 2, so back-to-back ADC needs no forwarding.
    always_comb begin
        sum_w  = {1'b0, s1_a_q} + {1'b0, s1_b_q}
               + {{WIDTH{1'b0}}, (s1_op_q == OP_ADC) & flags_q[F_C]};
        diff_w = {1'b0, s1_a_q} - {1'b0, s1_b_q};
        gt_w   = SIGNED_GT ? ($signed(s1_a_q) > $signed(s1_b_q)) : (s1_a_q > s1_b_q);

        alu_r       = s1_a_q;
        result_d    = s1_a_q;
        result_we_d = 1'b1;
        c_nxt       = flags_q[F_C];
        gt_nxt      = flags_q[F_GT];
        eq_nxt      = flags_q[F_EQ];
        upd_zsp     = 1'b1;

        case (s1_op_q)
            OP_ADD, OP_ADC: begin
                alu_r = sum_w[WIDTH-1:0];
                c_nxt = sum_w[WIDTH];
            end
            OP_SUB, OP_CMP: begin
                alu_r  = diff_w[WIDTH-1:0];
                c_nxt  = diff_w[WIDTH];
                gt_nxt = gt_w;
                eq_nxt = (s1_a_q == s1_b_q);
            end
            OP_AND: begin
                alu_r = s1_a_q & s1_b_q;
                c_nxt = 1'b0;
            end
            OP_OR: begin
                alu_r = s1_a_q | s1_b_q;
                c_nxt = 1'b0;
            end
            OP_XOR: begin
                alu_r = s1_a_q ^ s1_b_q;
                c_nxt = 1'b0;
            end
            default: begin
                upd_zsp = 1'b0;
            end
        endcase

        if (s1_op_q == OP_CMP) begin
            result_we_d = 1'b0;
        end else begin
            result_d = alu_r;
        end

        flags_d = {upd_zsp ? ~^alu_r           : flags_q[F_P],
                   eq_nxt,
                   gt_nxt,
                   upd_zsp ? alu_r[WIDTH-1]    : flags_q[F_S],
                   upd_zsp ? (alu_r == '0)     : flags_q[F_Z],
                   c_nxt};
    end

    // Flush outranks stall; idle slots leave result/flags untouched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_q    <= 1'b0;
            s1_op_q       <= '0;
            s1_a_q        <= '0;
            s1_b_q        <= '0;
            result_q      <= '0;
            flags_q       <= '0;
            flags_valid_q <= 1'b0;
            result_we_q   <= 1'b0;
        end else if (flush) begin
            s1_valid_q    <= 1'b0;
            flags_valid_q <= 1'b0;
            result_we_q   <= 1'b0;
        end else if (!stall) begin
            s1_valid_q    <= in_valid;
            s1_op_q       <= op;
            s1_a_q        <= a;
            s1_b_q        <= b;
            flags_valid_q <= s1_valid_q;
            result_we_q   <= s1_valid_q & result_we_d;
            if (s1_valid_q) begin
                result_q <= result_d;
                flags_q  <= flags_d;
            end
        end
    end

`ifdef FLAG_ZERO_CNT_EN
    logic [15:0] zero_cnt_q;
    logic        load_en;

    // Count at the load edge itself so a held strobe during stall is not counted twice.
    assign load_en = s1_valid_q & ~stall & ~flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            zero_cnt_q <= '0;
        end else if (zero_cnt_clr) begin
            zero_cnt_q <= '0;
        end else if (load_en && flags_d[F_Z] && (zero_cnt_q != 16'hFFFF)) begin
            zero_cnt_q <= zero_cnt_q + 16'd1;
        end
    end

    assign zero_cnt = zero_cnt_q;
`endif

    assign result_out  = result_q;
    assign result_we   = result_we_q;
    assign flags_out   = flags_q;
    assign flags_valid = flags_valid_q;

endmodule

// File: tb/tb_flag_unit.sv
// tb/tb_flag_unit.sv - scoreboard bench for flag_unit (unsigned and signed-compare instances side by side)
module tb_flag_unit;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_CMP  = 3'd2;
    localparam logic [2:0] OP_AND  = 3'd3;
    localparam logic [2:0] OP_OR   = 3'd4;
    localparam logic [2:0] OP_XOR  = 3'd5;
    localparam logic [2:0] OP_ADC  = 3'd6;
    localparam logic [2:0] OP_PASS = 3'd7;

    logic        clk      = 1'b0;
    logic        reset    = 1'b0;
    logic        in_valid = 1'b0;
    logic [2:0]  op       = '0;
    logic [15:0] a        = '0;
    logic [15:0] b        = '0;
    logic        stall    = 1'b0;
    logic        flush    = 1'b0;

    logic [15:0] result_out, s_result_out;
    logic        result_we, s_result_we;
    logic [5:0]  flags_out, s_flags_out;
    logic        flags_valid, s_flags_valid;

`ifdef FLAG_ZERO_CNT_EN
    logic        zero_cnt_clr = 1'b0;
    logic [15:0] zero_cnt, s_zero_cnt;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [15:0] res;
        logic [5:0]  flg;
        logic        we;
        logic [5:0]  flg_s;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    flag_unit #(.WIDTH(16), .SIGNED_GT(1'b0)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .op(op), .a(a), .b(b),
        .stall(stall), .flush(flush),
`ifdef FLAG_ZERO_CNT_EN
        .zero_cnt_clr(zero_cnt_clr), .zero_cnt(zero_cnt),
`endif
        .result_out(result_out), .result_we(result_we),
        .flags_out(flags_out), .flags_valid(flags_valid)
    );

    flag_unit #(.WIDTH(16), .SIGNED_GT(1'b1)) dut_s (
        .clk(clk), .reset(reset), .in_valid(in_valid), .op(op), .a(a), .b(b),
        .stall(stall), .flush(flush),
`ifdef FLAG_ZERO_CNT_EN
        .zero_cnt_clr(zero_cnt_clr), .zero_cnt(s_zero_cnt),
`endif
        .result_out(s_result_out), .result_we(s_result_we),
        .flags_out(s_flags_out), .flags_valid(s_flags_valid)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y,
                         input logic [15:0] er, input logic [5:0] ef, input logic ew,
                         input logic [5:0] efs);
        exp_t e;
        e.res   = er;
        e.flg   = ef;
        e.we    = ew;
        e.flg_s = efs;
        exp_q.push_back(e);
        in_valid = 1'b1;
        op       = o;
        a        = x;
        b        = y;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        check("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    // Outputs produced at an edge where stall (without flush) was applied must be frozen.
    logic edge_hold = 1'b0;
    always @(posedge clk) edge_hold <= stall && !flush;

    logic [15:0] snap_res   = '0;
    logic [5:0]  snap_flg   = '0;
    logic [5:0]  snap_flg_s = '0;
    logic        snap_fv    = 1'b0;
    logic        snap_we    = 1'b0;

    always @(negedge clk) begin
        if (!reset) begin
            snap_res   = '0;
            snap_flg   = '0;
            snap_flg_s = '0;
            snap_fv    = 1'b0;
            snap_we    = 1'b0;
        end else if (edge_hold) begin
            check("stall_result", 32'(result_out), 32'(snap_res));
            check("stall_flags", 32'(flags_out), 32'(snap_flg));
            check("stall_flags_valid", 32'(flags_valid), 32'(snap_fv));
            check("stall_result_we", 32'(result_we), 32'(snap_we));
            check("stall_flags_s", 32'(s_flags_out), 32'(snap_flg_s));
        end else if (flags_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_flags_valid: got 1 expected 0 at %0t", $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("result_out", 32'(result_out), 32'(mon_e.res));
                check("flags_out", 32'(flags_out), 32'(mon_e.flg));
                check("result_we", 32'(result_we), 32'(mon_e.we));
                check("s_flags_valid", 32'(s_flags_valid), 32'd1);
                check("s_result_out", 32'(s_result_out), 32'(mon_e.res));
                check("s_result_we", 32'(s_result_we), 32'(mon_e.we));
                check("s_flags_out", 32'(s_flags_out), 32'(mon_e.flg_s));
                snap_res   = mon_e.res;
                snap_flg   = mon_e.flg;
                snap_flg_s = mon_e.flg_s;
                snap_fv    = 1'b1;
                snap_we    = mon_e.we;
            end
        end else begin
            check("idle_flags", 32'(flags_out), 32'(snap_flg));
            check("idle_result", 32'(result_out), 32'(snap_res));
            check("idle_result_we", 32'(result_we), 32'd0);
            check("idle_flags_s", 32'(s_flags_out), 32'(snap_flg_s));
            snap_fv = 1'b0;
            snap_we = 1'b0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        check("reset_result", 32'(result_out), 32'd0);
        check("reset_flags", 32'(flags_out), 32'd0);
        check("reset_flags_valid", 32'(flags_valid), 32'd0);
        check("reset_result_we", 32'(result_we), 32'd0);
        reset = 1'b1;
        tick();

        // Wrap-around ADD then back-to-back ADC consuming its carry, followed by one of each op.
        issue(OP_ADD,  16'hFFFF, 16'h0001, 16'h0000, 6'h23, 1'b1, 6'h23);
        issue(OP_ADC,  16'h0001, 16'h0001, 16'h0003, 6'h20, 1'b1, 6'h20);
        issue(OP_SUB,  16'h0005, 16'h0007, 16'hFFFE, 6'h05, 1'b1, 6'h05);
        issue(OP_CMP,  16'h0001, 16'hFFFF, 16'h0001, 6'h01, 1'b0, 6'h09);
        issue(OP_SUB,  16'h8000, 16'h0001, 16'h7FFF, 6'h08, 1'b1, 6'h00);
        issue(OP_CMP,  16'h1234, 16'h1234, 16'h1234, 6'h32, 1'b0, 6'h32);
        issue(OP_AND,  16'hF0F0, 16'h0FF0, 16'h00F0, 6'h30, 1'b1, 6'h30);
        issue(OP_OR,   16'h8000, 16'h0001, 16'h8001, 6'h34, 1'b1, 6'h34);
        issue(OP_XOR,  16'hAAAA, 16'h5555, 16'hFFFF, 6'h34, 1'b1, 6'h34);
        issue(OP_PASS, 16'hBEEF, 16'h0000, 16'hBEEF, 6'h34, 1'b1, 6'h34);
        drain();

        // Four-op stream with a two-cycle stall in the middle; a junk op offered during stall must be ignored.
        issue(OP_ADD, 16'h0001, 16'h0002, 16'h0003, 6'h30, 1'b1, 6'h30);
        issue(OP_XOR, 16'h00FF, 16'h00FF, 16'h0000, 6'h32, 1'b1, 6'h32);
        stall    = 1'b1;
        in_valid = 1'b1;
        op       = OP_ADD;
        a        = 16'h0000;
        b        = 16'h0000;
        tick();
        tick();
        stall    = 1'b0;
        in_valid = 1'b0;
        issue(OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 6'h14, 1'b1, 6'h14);
        issue(OP_SUB, 16'h0003, 16'h0002, 16'h0001, 6'h08, 1'b1, 6'h08);
        drain();

        // Flush (with stall also high) while one op sits in stage 1 and another is on the inputs.
        in_valid = 1'b1;
        op       = OP_ADD;
        a        = 16'h00FF;
        b        = 16'h0001;
        tick();
        op    = OP_SUB;
        a     = 16'h0009;
        b     = 16'h0009;
        flush = 1'b1;
        stall = 1'b1;
        tick();
        flush    = 1'b0;
        stall    = 1'b0;
        in_valid = 1'b0;
        tick();
        tick();
        check("flush_flags_valid", 32'(flags_valid), 32'd0);
        check("flush_flags_kept", 32'(flags_out), 32'h08);
        check("flush_result_kept", 32'(result_out), 32'h0001);

        // Asynchronous reset dropped between edges with an op still in stage 1.
        issue(OP_ADD, 16'h0010, 16'h0020, 16'h0030, 6'h28, 1'b1, 6'h28);
        in_valid = 1'b1;
        op       = OP_ADD;
        a        = 16'h0005;
        b        = 16'h0005;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_result", 32'(result_out), 32'd0);
        check("async_reset_flags", 32'(flags_out), 32'd0);
        check("async_reset_flags_valid", 32'(flags_valid), 32'd0);
        check("async_reset_result_we", 32'(result_we), 32'd0);
        check("async_reset_flags_s", 32'(s_flags_out), 32'd0);
        check("async_reset_pending", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        tick();
        tick();
        reset = 1'b1;
        tick();
        tick();
        check("post_reset_flags_valid", 32'(flags_valid), 32'd0);

`ifdef FLAG_ZERO_CNT_EN
        check("zero_cnt_reset", 32'(zero_cnt), 32'd0);
        issue(OP_XOR, 16'h1111, 16'h1111, 16'h0000, 6'h22, 1'b1, 6'h22);
        issue(OP_XOR, 16'h1111, 16'h1111, 16'h0000, 6'h22, 1'b1, 6'h22);
        issue(OP_XOR, 16'h1111, 16'h1111, 16'h0000, 6'h22, 1'b1, 6'h22);
        drain();
        tick();
        check("zero_cnt_three", 32'(zero_cnt), 32'd3);
        check("s_zero_cnt_three", 32'(s_zero_cnt), 32'd3);
        zero_cnt_clr = 1'b1;
        tick();
        zero_cnt_clr = 1'b0;
        check("zero_cnt_cleared", 32'(zero_cnt), 32'd0);
`endif

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/flag_unit.md
Name: flag_unit

Overview:
- Two-stage pipelined flag generator sitting directly upstream of the 6-bit flag register.
- Accepts an ALU operation with operands, computes the 16-bit result and the six status flags, and presents them registered with a load strobe.
- The flag register captures flags_out when flags_valid=1.
- flags_out holds the last committed flags, so it also serves as the "keep" source for flags an operation does not update.

Parameters:
- WIDTH, 16, operand and result width in bits.
- SIGNED_GT, 0, 0 = greater_than is an unsigned compare; 1 = two's-complement compare.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  operation present on op/a/b this cycle
- op  input  3  operation code (see Behaviour)
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- stall  input  1  freeze both stages
- flush  input  1  kill in-flight operations
- result_out  output  WIDTH  registered result
- result_we  output  1  result_out valid for register-file write
- flags_out  output  6  [0] carry, [1] zero, [2] sign, [3] greater_than, [4] equal, [5] even parity
- flags_valid  output  1  one-cycle load strobe for the flag register

Behaviour:
- Reset (reset=0, asynchronous): s1_valid, flags_valid and result_we are 0; result_out and flags_out are 0; stage-1 operand registers are 0.
- Stage 1 (input register): if stall=0, captures in_valid/op/a/b at the rising edge.
- Stage 2 (compute/output): if stall=0, computes from the stage-1 contents and registers the outputs.
- Latency: an op accepted at edge N produces flags_valid=1 after edge N+1 (2 cycles). Throughput is 1 op per cycle.
- stall=1: both stages hold all registers. flags_valid and result_we hold their values; the flag register treats a held strobe as a repeat load of identical data, which is harmless. in_valid is ignored.
- flush=1 (stall=0): s1_valid and flags_valid/result_we are cleared at the next edge. flags_out and result_out keep their values.
- flush and stall both 1: flush wins.
- Idle stage-2 slot (s1_valid=0): flags_valid=0, result_we=0, flags_out unchanged.
- Arithmetic uses a WIDTH+1 bit sum. Definitions:
  - Z = (r==0)
  - S = r[WIDTH-1]
  - P = ~^r over all WIDTH bits (1 = even count of ones)
  - K = keep the current flags_out bit
- Op codes:
  - 000 ADD: r=a+b; C=carry out; Z,S,P from r; GT,EQ K; result_we=1.
  - 001 SUB: r=a-b; C=borrow (a<b unsigned); Z,S,P; GT=a>b (per SIGNED_GT); EQ=(a==b); result_we=1.
  - 010 CMP: same flags as SUB; result_out=a; result_we=0.
  - 011 AND, 100 OR, 101 XOR: C=0; Z,S,P from r; GT,EQ K; result_we=1.
  - 110 ADC: r=a+b+flags_out[0] (the current registered carry); C,Z,S,P updated; GT,EQ K; result_we=1.
  - 111 PASS: r=a; all six flags K; flags_valid=1; result_we=1.
- Back-to-back ADC: the second ADC uses the carry committed by the first at the preceding edge. No forwarding hazard exists because carry is read in stage 2.
- Wrap-around: ADD 0xFFFF+0x0001 gives r=0x0000, C=1, Z=1, P=1.
- Reset mid-operation: in-flight ops are discarded and flags return to 0.

Optional Feature:
- Macro: FLAG_ZERO_CNT_EN.
- Defined:
  - Adds output port zero_cnt (16 bits) and input port zero_cnt_clr (1 bit).
  - zero_cnt increments on each edge where flags_valid is set with Z=1, and saturates at 0xFFFF.
  - zero_cnt_clr=1 synchronously clears it; clear has priority over increment.
  - Reset value is 0.
- Undefined: the ports and the counter are absent; all other behaviour is identical.

Test Plan:
- ADD a=0xFFFF, b=0x0001 -> 2 cycles later: result_out=0x0000, flags_out=6'b100011 (P,Z,C), flags_valid=1, result_we=1.
- SUB a=0x0005, b=0x0007 -> result_out=0xFFFE, C=1, S=1, Z=0, GT=0, EQ=0, P=0. With SIGNED_GT=1, CMP a=0x0001, b=0xFFFF -> GT=1, result_we=0.
- ADD 0xFFFF+0x0001, then back-to-back ADC 0x0001+0x0001 -> second result 0x0003, C=0. GT/EQ bits are unchanged from before the sequence.
- Stream of 4 ops with stall=1 for 2 cycles in the middle -> outputs frozen during stall, all 4 results appear in order, none lost or duplicated.
- flush asserted with 2 ops in flight -> no flags_valid pulses for them; flags_out equals the last committed value.
- reset driven low asynchronously mid-stream -> all outputs 0 immediately. With FLAG_ZERO_CNT_EN defined, 3 zero results then zero_cnt_clr -> zero_cnt reads 3, then 0.
